// File: rtl/inventory_pkg.sv
// Shared types and limits for the inventory tracker and its per-slot logic.
package inventory_pkg;

  localparam int unsigned MAX_SLOTS = 16;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_HELD
  } slot_state_e;

endpackage

// File: rtl/inventory_tracker_if.sv
// Event/status bundle between room logic (master) and the inventory tracker (slave).
interface inventory_tracker_if #(
  parameter int unsigned NUM_ITEMS = 4,
  parameter int unsigned CNT_W     = 3
);

  logic                       clear;
  logic [NUM_ITEMS-1:0]       found;
  logic [NUM_ITEMS-1:0]       use_req;
  logic [NUM_ITEMS-1:0]       has;
  logic [NUM_ITEMS*CNT_W-1:0] count;
  logic [NUM_ITEMS-1:0]       use_grant;
  logic [NUM_ITEMS-1:0]       use_deny;
  logic [NUM_ITEMS-1:0]       sat;
  logic                       all_keys;

  modport master (
    output clear, found, use_req,
    input  has, count, use_grant, use_deny, sat, all_keys
  );

  modport slave (
    input  clear, found, use_req,
    output has, count, use_grant, use_deny, sat, all_keys
  );

endinterface

// File: rtl/inventory_slot.sv
// One inventory slot: sticky key flag or saturating consumable counter, plus the
// registered grant/deny/sat pulses for that slot.
module inventory_slot
  import inventory_pkg::*;
#(
  parameter int unsigned CNT_W      = 3,
  parameter bit          CONSUMABLE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_found,
  input  logic             i_use_req,
  output logic             o_has,
  output logic [CNT_W-1:0] o_count,
  output logic             o_grant,
  output logic             o_deny,
  output logic             o_sat
);

  logic w_rst;
  logic r_grant, r_deny, r_sat;

  assign w_rst   = reset | i_clear;
  assign o_grant = r_grant;
  assign o_deny  = r_deny;
  assign o_sat   = r_sat;

  if (CONSUMABLE) begin : g_cons
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             w_grant_d, w_deny_d, w_sat_d;

    // Use is judged on the pre-update count; a simultaneous pickup then refills it.
    always_comb begin
      w_cnt_d   = r_cnt;
      w_grant_d = 1'b0;
      w_deny_d  = 1'b0;
      w_sat_d   = 1'b0;
      if (i_use_req) begin
        if (r_cnt != '0) begin
          w_grant_d = 1'b1;
          if (!i_found) w_cnt_d = r_cnt - 1'b1;
        end else begin
          w_deny_d = 1'b1;
          if (i_found) w_cnt_d = CNT_W'(1);
        end
      end else if (i_found) begin
        if (r_cnt == CntMax) w_sat_d = 1'b1;
        else                 w_cnt_d = r_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_rst) begin
        r_cnt   <= '0;
        r_grant <= 1'b0;
        r_deny  <= 1'b0;
        r_sat   <= 1'b0;
      end else begin
        r_cnt   <= w_cnt_d;
        r_grant <= w_grant_d;
        r_deny  <= w_deny_d;
        r_sat   <= w_sat_d;
      end
    end

    assign o_has   = (r_cnt != '0);
    assign o_count = r_cnt;

  end else begin : g_key
    slot_state_e r_state;
    logic        w_held;

    assign w_held = (r_state == SLOT_HELD);

    always_ff @(posedge clk) begin
      if (w_rst) begin
        r_state <= SLOT_EMPTY;
        r_grant <= 1'b0;
        r_deny  <= 1'b0;
        r_sat   <= 1'b0;
      end else begin
        if (i_found) r_state <= SLOT_HELD;
        r_grant <= i_use_req & w_held;
        r_deny  <= i_use_req & ~w_held;
        r_sat   <= 1'b0;
      end
    end

    assign o_has   = w_held;
    assign o_count = CNT_W'(w_held);
  end

endmodule

// File: rtl/inventory_tracker.sv
// Tracks NUM_ITEMS adventure items (sticky keys and counted consumables) and
// reports per-slot status, use handshake pulses and the all-keys flag.
module inventory_tracker
  import inventory_pkg::*;
#(
  parameter int unsigned          NUM_ITEMS       = 4,
  parameter int unsigned          CNT_W           = 3,
  parameter logic [NUM_ITEMS-1:0] CONSUMABLE_MASK = 4'b1100
) (
  input logic                clk,
  input logic                reset,
  inventory_tracker_if.slave bus
);

  if (NUM_ITEMS < 1 || NUM_ITEMS > MAX_SLOTS || CNT_W < 1 ||
      $bits(CONSUMABLE_MASK) != NUM_ITEMS) begin : g_param_err
    $error("inventory_tracker: bad NUM_ITEMS/CNT_W/CONSUMABLE_MASK");
  end

  logic [NUM_ITEMS-1:0]       w_has, w_grant, w_deny, w_sat;
  logic [NUM_ITEMS*CNT_W-1:0] w_count;

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_slot
    inventory_slot #(
      .CNT_W      (CNT_W),
      .CONSUMABLE (CONSUMABLE_MASK[g])
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (bus.clear),
      .i_found   (bus.found[g]),
      .i_use_req (bus.use_req[g]),
      .o_has     (w_has[g]),
      .o_count   (w_count[g*CNT_W +: CNT_W]),
      .o_grant   (w_grant[g]),
      .o_deny    (w_deny[g]),
      .o_sat     (w_sat[g])
    );
  end

  assign bus.has       = w_has;
  assign bus.count     = w_count;
  assign bus.use_grant = w_grant;
  assign bus.use_deny  = w_deny;
  assign bus.sat       = w_sat;
  // Consumable slots are forced high so they never block the key AND-reduction.
  assign bus.all_keys  = &(w_has | CONSUMABLE_MASK);

endmodule

// File: tb/tb_inventory_tracker.sv
// Directed and model-checked bench for inventory_tracker (4 slots, CNT_W=3, mask 4'b1100).
module tb_inventory_tracker;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;
  localparam logic [3:0]  CM = 4'b1100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  inventory_tracker_if #(.NUM_ITEMS(N), .CNT_W(CW)) bus ();

  inventory_tracker #(
    .NUM_ITEMS       (N),
    .CNT_W           (CW),
    .CONSUMABLE_MASK (CM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] cnt_of(input int i);
    return bus.count[i*3 +: 3];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clear   = 1'b0;
    bus.found   = '0;
    bus.use_req = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    bus.found = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.has !== 4'h0) $display("FAIL reset_has cyc%0d: got %b want 0000", k, bus.has);
      else n_pass++;
      n_checks++;
      if (bus.count !== 12'h000) $display("FAIL reset_count cyc%0d: got %h want 000", k, bus.count);
      else n_pass++;
      n_checks++;
      if ({bus.use_grant, bus.use_deny, bus.sat} !== 12'h000)
        $display("FAIL reset_pulses cyc%0d: got %h want 000", k,
                 {bus.use_grant, bus.use_deny, bus.sat});
      else n_pass++;
    end
    n_checks++;
    if (bus.all_keys !== 1'b0) $display("FAIL reset_all_keys: got %b want 0", bus.all_keys);
    else n_pass++;
    reset = 1'b0;
    idle();
  endtask

  task automatic test_key();
    do_reset();
    bus.found = 4'b0001;
    tick();
    bus.found = '0;
    n_checks++;
    if (bus.has !== 4'b0001) $display("FAIL key_has: got %b want 0001", bus.has);
    else n_pass++;
    tick();
    tick();
    bus.use_req = 4'b0001;
    tick();
    bus.use_req = '0;
    n_checks++;
    if ({bus.use_grant, bus.use_deny, bus.has} !== 12'b0001_0000_0001)
      $display("FAIL key_use: got g=%b d=%b h=%b want g=0001 d=0000 h=0001",
               bus.use_grant, bus.use_deny, bus.has);
    else n_pass++;
    bus.use_req = 4'b0010;
    tick();
    bus.use_req = '0;
    n_checks++;
    if ({bus.use_grant, bus.use_deny} !== 8'b0000_0010)
      $display("FAIL key_deny: got g=%b d=%b want g=0000 d=0010", bus.use_grant, bus.use_deny);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.use_grant, bus.use_deny} !== 8'h00)
      $display("FAIL key_pulse_end: got g=%b d=%b want 0", bus.use_grant, bus.use_deny);
    else n_pass++;
    n_checks++;
    if (bus.all_keys !== 1'b0) $display("FAIL key_all_keys_lo: got %b want 0", bus.all_keys);
    else n_pass++;
    bus.found = 4'b0011;
    tick();
    bus.found = '0;
    n_checks++;
    if ({bus.all_keys, cnt_of(0), cnt_of(1), bus.sat} !== {1'b1, 3'd1, 3'd1, 4'b0000})
      $display("FAIL key_all_keys_hi: got ak=%b c0=%0d c1=%0d sat=%b want ak=1 c0=1 c1=1 sat=0000",
               bus.all_keys, cnt_of(0), cnt_of(1), bus.sat);
    else n_pass++;
  endtask

  task automatic test_consumable();
    int exp_c;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      bus.found = 4'b0100;
      tick();
      exp_c = (k < 7) ? k : 7;
      n_checks++;
      if (cnt_of(2) !== 3'(exp_c) || bus.sat[2] !== (k >= 8))
        $display("FAIL cons_found%0d: got c=%0d sat=%b want c=%0d sat=%b",
                 k, cnt_of(2), bus.sat[2], exp_c, (k >= 8));
      else n_pass++;
    end
    idle();
    for (int k = 1; k <= 8; k++) begin
      bus.use_req = 4'b0100;
      tick();
      exp_c = (k <= 7) ? 7 - k : 0;
      n_checks++;
      if (cnt_of(2) !== 3'(exp_c) || bus.use_grant[2] !== (k <= 7) || bus.use_deny[2] !== (k > 7))
        $display("FAIL cons_use%0d: got c=%0d g=%b d=%b want c=%0d g=%b d=%b", k, cnt_of(2),
                 bus.use_grant[2], bus.use_deny[2], exp_c, (k <= 7), (k > 7));
      else n_pass++;
    end
    idle();
    n_checks++;
    if (bus.has[2] !== 1'b0) $display("FAIL cons_empty_has: got %b want 0", bus.has[2]);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.found = 4'b1000;
    bus.use_req = 4'b1000;
    tick();
    n_checks++;
    if ({bus.use_grant[3], bus.use_deny[3], cnt_of(3)} !== {1'b0, 1'b1, 3'd1})
      $display("FAIL simul_empty: got g=%b d=%b c=%0d want g=0 d=1 c=1",
               bus.use_grant[3], bus.use_deny[3], cnt_of(3));
    else n_pass++;
    bus.use_req = '0;
    for (int k = 0; k < 6; k++) tick();
    n_checks++;
    if (cnt_of(3) !== 3'd7) $display("FAIL simul_fill: got %0d want 7", cnt_of(3));
    else n_pass++;
    bus.use_req = 4'b1000;
    tick();
    idle();
    n_checks++;
    if ({bus.use_grant[3], bus.use_deny[3], bus.sat[3], cnt_of(3)} !== {3'b100, 3'd7})
      $display("FAIL simul_full: got g=%b d=%b s=%b c=%0d want g=1 d=0 s=0 c=7",
               bus.use_grant[3], bus.use_deny[3], bus.sat[3], cnt_of(3));
    else n_pass++;
  endtask

  task automatic test_clear();
    do_reset();
    bus.found = 4'b0101;
    for (int k = 0; k < 5; k++) tick();
    idle();
    n_checks++;
    if (cnt_of(2) !== 3'd5 || bus.has !== 4'b0101)
      $display("FAIL clear_setup: got c=%0d h=%b want c=5 h=0101", cnt_of(2), bus.has);
    else n_pass++;
    bus.use_req = 4'b0101;
    bus.clear = 1'b1;
    tick();
    idle();
    n_checks++;
    if ({bus.use_grant, bus.use_deny, bus.has, bus.count} !== 24'h0)
      $display("FAIL clear_mid: got g=%b d=%b h=%b cnt=%h want all 0",
               bus.use_grant, bus.use_deny, bus.has, bus.count);
    else n_pass++;
  endtask

  task automatic test_random();
    int          m_cnt[4];
    logic [3:0]  f, u, eg, ed, es, eh;
    logic [11:0] ec;
    int          errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      f = 4'($urandom_range(0, 15));
      u = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      eg = '0; ed = '0; es = '0;
      for (int i = 0; i < 4; i++) begin
        if (u[i]) begin
          if (m_cnt[i] > 0) eg[i] = 1'b1;
          else ed[i] = 1'b1;
        end
        if (!CM[i]) begin
          if (f[i]) m_cnt[i] = 1;
        end else if (u[i] && f[i]) begin
          if (m_cnt[i] == 0) m_cnt[i] = 1;
        end else if (u[i]) begin
          if (m_cnt[i] > 0) m_cnt[i]--;
        end else if (f[i]) begin
          if (m_cnt[i] == 7) es[i] = 1'b1;
          else m_cnt[i]++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        eh[i] = (m_cnt[i] != 0);
        ec[i*3 +: 3] = 3'(m_cnt[i]);
      end
      bus.found = f;
      bus.use_req = u;
      tick();
      n_checks++;
      if ({bus.use_grant, bus.use_deny, bus.sat, bus.has, bus.count, bus.all_keys} !==
          {eg, ed, es, eh, ec, &(eh | CM)}) begin
        if (errs < 10)
          $display("FAIL rand cyc%0d: got g=%b d=%b s=%b h=%b c=%h ak=%b want g=%b d=%b s=%b h=%b c=%h ak=%b",
                   cyc, bus.use_grant, bus.use_deny, bus.sat, bus.has, bus.count, bus.all_keys,
                   eg, ed, es, eh, ec, &(eh | CM));
        errs++;
      end else n_pass++;
      n_checks++;
      if ((bus.use_grant & bus.use_deny) !== 4'b0000) begin
        if (errs < 10) $display("FAIL rand_excl cyc%0d: got %b want 0000", cyc,
                                bus.use_grant & bus.use_deny);
        errs++;
      end else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_key();
    test_consumable();
    test_simultaneous();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
